// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and counter sizing for divider_seq_nb
// Contents: state_t (IDLE/RUN/DONE) and cnt_w(n), the bit counter width able to hold n.
package divider_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {R,Q} against divisor B
// Ports: r_i/q_i partial remainder and quotient/dividend shift register, b_i divisor,
//        r_o/q_o values after shift, trial subtract and conditional restore.
module div_step #(parameter int n = 4) (
   input  logic [n-1:0] r_i,
   input  logic [n-1:0] q_i,
   input  logic [n-1:0] b_i,
   output logic [n-1:0] r_o,
   output logic [n-1:0] q_o
);
   logic [n:0] r_sh;
   logic [n:0] trial;
   assign r_sh  = {r_i, q_i[n-1]};
   assign trial = r_sh - {1'b0, b_i};
   // trial MSB set means the subtract went negative: keep the shifted remainder
   assign r_o = trial[n] ? r_sh[n-1:0] : trial[n-1:0];
   assign q_o = {q_i[n-2:0], ~trial[n]};
endmodule

// File: rtl/divider_seq_nb.sv
// divider_seq_nb: sequential n-bit unsigned restoring divider, one quotient bit per clock
// Ports: clk, rst (sync, active-high); start/a/b issue a divide from IDLE;
//        busy high in RUN, done one-cycle result pulse; Quotient/Remainder/DivZero
//        registered on entry to DONE and held until the next DONE.
module divider_seq_nb
   import divider_pkg::*;
#(parameter int n = 4) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] Quotient,
   output logic [n-1:0] Remainder,
   output logic         DivZero
);
   localparam int CNT_W = cnt_w(n);
   state_t           state_q;
   logic [n-1:0]     r_q, q_q, b_q, quot_q, rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dz_q;
   logic [n-1:0]     r_d, q_d;
   div_step #(.n(n)) u_step (.r_i(r_q), .q_i(q_q), .b_i(b_q), .r_o(r_d), .q_o(q_d));
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               q_q   <= a;
               b_q   <= b;
               r_q   <= '0;
               cnt_q <= CNT_W'(n);
               // zero divisor skips RUN and reports saturated quotient
               if (b == '0) begin
                  state_q <= DONE;
                  quot_q  <= '1;
                  rem_q   <= a;
                  dz_q    <= 1'b1;
               end else begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  quot_q  <= q_d;
                  rem_q   <= r_d;
                  dz_q    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign Quotient  = quot_q;
   assign Remainder = rem_q;
   assign DivZero   = dz_q;
endmodule

// File: tb/tb_divider_seq_nb.sv
// tb_divider_seq_nb: directed and exhaustive self-checking bench for divider_seq_nb (n=4)
module tb_divider_seq_nb;
   localparam int N = 4;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         busy, done, dz;
   logic [N-1:0] quo, rem;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   divider_seq_nb #(.n(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .Quotient(quo), .Remainder(rem), .DivZero(dz)
   );

   // issue one divide and wait (bounded) for done; cyc=-1 on timeout
   task automatic run_div(input logic [N-1:0] av, input logic [N-1:0] bv, output int cyc, output int bcnt);
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; cyc = 1; bcnt = 0;
      while (!done && cyc < 20) begin
         bcnt += int'(busy);
         @(negedge clk);
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset();
      int cyc, bc;
      rst = 1'b1; start = 1'b1; a = 4'd13; b = 4'd3;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, done, quo, rem, dz} !== 11'b0) begin
         fails++;
         $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, quo, rem, dz);
      end
      rst = 1'b0; start = 1'b0;
      run_div(4'd13, 4'd3, cyc, bc);
      tests++;
      if (cyc !== 5) begin fails++; $display("FAIL reset_latency got %0d want 5", cyc); end
      tests++;
      if (bc !== 4) begin fails++; $display("FAIL reset_busy_cycles got %0d want 4", bc); end
      tests++;
      if ({quo, rem, dz} !== {4'b0100, 4'b0001, 1'b0}) begin
         fails++;
         $display("FAIL reset_13div3 got q=%b r=%b dz=%b want q=0100 r=0001 dz=0", quo, rem, dz);
      end
   endtask

   task automatic test_limits();
      logic [N-1:0] av [3] = '{4'b1111, 4'b1111, 4'b0000};
      logic [N-1:0] bv [3] = '{4'b1111, 4'b0001, 4'b0101};
      logic [N-1:0] eq [3] = '{4'b0001, 4'b1111, 4'b0000};
      logic [N-1:0] er [3] = '{4'b0000, 4'b0000, 4'b0000};
      int cyc, bc;
      for (int i = 0; i < 3; i++) begin
         run_div(av[i], bv[i], cyc, bc);
         tests++;
         if (cyc !== 5 || {quo, rem, dz} !== {eq[i], er[i], 1'b0}) begin
            fails++;
            $display("FAIL limits_%0d got cyc=%0d q=%b r=%b dz=%b want cyc=5 q=%b r=%b dz=0", i, cyc, quo, rem, dz, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_divzero();
      int cyc, bc;
      run_div(4'b0111, 4'b0000, cyc, bc);
      tests++;
      if (cyc !== 1) begin fails++; $display("FAIL divzero_latency got %0d want 1", cyc); end
      tests++;
      if (bc !== 0 || busy !== 1'b0) begin fails++; $display("FAIL divzero_busy got %0d want 0", bc); end
      tests++;
      if ({quo, rem, dz} !== {4'b1111, 4'b0111, 1'b1}) begin
         fails++;
         $display("FAIL divzero_result got q=%b r=%b dz=%b want q=1111 r=0111 dz=1", quo, rem, dz);
      end
   endtask

   task automatic test_busy_protect();
      int nd = 0;
      logic [N-1:0] gq = '0, gr = '0;
      @(negedge clk);
      start = 1'b1; a = 4'd9; b = 4'd2;
      @(negedge clk);
      start = 1'b1; a = 4'd15; b = 4'd1;
      @(negedge clk);
      start = 1'b0; a = 4'd3; b = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin nd++; gq = quo; gr = rem; end
         @(negedge clk);
      end
      tests++;
      if (nd !== 1) begin fails++; $display("FAIL busy_done_count got %0d want 1", nd); end
      tests++;
      if ({gq, gr} !== {4'b0100, 4'b0001}) begin
         fails++;
         $display("FAIL busy_result got q=%b r=%b want q=0100 r=0001", gq, gr);
      end
   endtask

   task automatic test_reset_mid();
      int nd = 0;
      @(negedge clk);
      start = 1'b1; a = 4'd14; b = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy, done, quo, rem, dz} !== 11'b0) begin
         fails++;
         $display("FAIL midreset_state got busy=%b done=%b q=%b r=%b dz=%b want all 0", busy, done, quo, rem, dz);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      tests++;
      if (nd !== 0) begin fails++; $display("FAIL midreset_no_done got %0d want 0", nd); end
   endtask

   task automatic test_back_to_back();
      int first = -1, second = -1;
      int nbad = 0;
      @(negedge clk);
      start = 1'b1; a = 4'd13; b = 4'd3;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done) begin
            if (first < 0) first = i; else if (second < 0) second = i;
            if ({quo, rem} !== {4'b0100, 4'b0001}) nbad++;
         end
      end
      start = 1'b0;
      repeat (10) @(negedge clk);
      tests++;
      if (first !== 5 || second !== 11) begin
         fails++;
         $display("FAIL b2b_done_times got %0d,%0d want 5,11", first, second);
      end
      tests++;
      if (nbad !== 0) begin fails++; $display("FAIL b2b_result got %0d bad results want 0", nbad); end
   endtask

   task automatic test_exhaustive();
      int cyc, bc;
      int nz = 0;
      logic [N-1:0] xq, xr;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            run_div(N'(i), N'(j), cyc, bc);
            xq = (j == 0) ? 4'b1111 : N'(i / j);
            xr = (j == 0) ? N'(i) : N'(i % j);
            if (dz) nz++;
            tests++;
            if (cyc !== ((j == 0) ? 1 : 5) || {quo, rem, dz} !== {xq, xr, j == 0}) begin
               fails++;
               $display("FAIL exh_%0d_%0d got cyc=%0d q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", i, j, cyc, quo, rem, dz, xq, xr, j == 0);
            end
         end
      end
      tests++;
      if (nz !== 16) begin fails++; $display("FAIL exh_divzero_count got %0d want 16", nz); end
   endtask

   initial begin
      test_reset();
      test_limits();
      test_divzero();
      test_busy_protect();
      test_reset_mid();
      test_back_to_back();
      test_exhaustive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/divider_seq_nb.md
Name: divider_seq_nb

Overview:
Sequential n-bit unsigned restoring divider. It is the inverse operation of the team's combinational multiplier_nb and shares its operand naming (a, b) and width parameter n. It resolves one quotient bit per clock and exposes a start/busy/done handshake so the ALU or a control FSM can issue a divide and collect Quotient/Remainder. It also flags divide-by-zero, analogous to the multiplier's Overf.

Parameters:
n, 4, operand/result width in bits (n >= 2)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a divide; sampled only in IDLE
a  input  n  dividend, unsigned; captured on the accepting edge
b  input  n  divisor, unsigned; captured on the accepting edge
busy  output  1  high while a division is in progress (RUN state)
done  output  1  one-cycle pulse: results valid
Quotient  output  n  a / b; held stable from done until next accepted start
Remainder  output  n  a % b; held stable from done until next accepted start
DivZero  output  1  set with done when captured b == 0; held like Quotient

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, Quotient=0, Remainder=0, DivZero=0, all internal registers cleared. rst overrides every other input on the same edge, including mid-RUN; the in-flight result is discarded and done does not fire.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, capture a into the quotient/dividend shift register, b into the divisor register, clear the partial remainder, load the bit counter with n.
  - If b != 0: go to RUN.
  - If b == 0: go directly to DONE with Quotient = all ones, Remainder = a, DivZero = 1.
- RUN: busy=1. Each edge performs one restoring step on the 2n-bit register pair {R,Q}:
  - shift left by 1;
  - trial = R_shifted - B, computed at n+1 bits;
  - if trial is non-negative: R = trial[n-1:0] and Q LSB = 1; otherwise keep R and Q LSB = 0;
  - decrement the counter. When the counter reaches 0 after this step, go to DONE.
- DONE: done=1 for exactly one cycle; Quotient and Remainder are driven from the registers; DivZero=0 unless the divide-by-zero path was taken. Next state is always IDLE.
- Latency, normal divide: start accepted at edge E0; RUN edges E1..En; done=1 in the cycle after En; back in IDLE after E(n+1). Total n+1 cycles from acceptance to done, n+2 to the next possible accept. Divide-by-zero: done in the cycle immediately after E0.
- start while RUN or DONE is ignored; no queuing, and captured operands are unaffected by changes on a/b.
- Output registers update only when entering DONE. Values hold through IDLE until the next DONE.
- A start held high continuously re-launches from IDLE every n+2 cycles.
- Arithmetic is purely unsigned. The remainder register needs n+1 bits only for the trial subtract; outputs are n bits. Invariant when DivZero=0: Quotient*b + Remainder == a and Remainder < b.

Decomposition:
- Package divider_pkg: state_t enum {IDLE, RUN, DONE} and localparam CNT_W = $clog2(n+1) expressed as a function of n.
- Sub-module div_step (combinational, parameter n): inputs R, Q, B; outputs next R and next Q for one restoring iteration. Instantiated once in the RUN datapath. It can be unit-tested independently.

Test Plan:
- Reset check: assert rst, then start with a=13, b=3 -> after n+1 cycles done=1 with Quotient=4'b0100, Remainder=4'b0001, DivZero=0; busy high for exactly 4 cycles.
- Operand-limit case: a=4'b1111, b=4'b1111 -> Quotient=0001, Remainder=0000; also a=1111, b=0001 -> Quotient=1111, Remainder=0000; also a=0000, b=0101 -> Quotient=0000, Remainder=0000.
- Divide-by-zero: a=0111, b=0000 -> done=1 one cycle after accept, DivZero=1, Quotient=1111, Remainder=0111, busy never asserted.
- Busy protection: start a=9, b=2, then pulse start with a=15, b=1 during RUN and change a/b -> single done with Quotient=0100, Remainder=0001; no second done.
- Reset mid-operation: start a=14, b=3, assert rst on the 2nd RUN edge -> next cycle busy=0, done=0, Quotient=0, Remainder=0; no done in the following 10 cycles.
- Exhaustive self-check: all 256 (a,b) pairs for n=4 -> results compared against the / and % operators; DivZero set exactly for the 16 pairs with b=0.
